// File: rtl/mppt_pkg.sv
// mppt_pkg: shared types and default constants for the perturb-and-observe
// MPPT controller.
//   state_t          - controller FSM states
//   DEF_DW / PW      - default sample width and matching power width
//   DEF_DUTY_*       - default duty setpoint limits, initial value and step
package mppt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_WAIT,
    S_COMPARE,
    S_UPDATE
  } state_t;

  localparam int DEF_DW         = 8;
  localparam int PW             = 2 * DEF_DW;
  localparam int DEF_DUTY_INIT  = 128;
  localparam int DEF_DUTY_MIN   = 16;
  localparam int DEF_DUTY_MAX   = 240;
  localparam int DEF_STEP       = 4;

endpackage

// File: rtl/mppt_po_controller_duty_stepper.sv
// duty_stepper: combinational saturating duty step.
//   duty       in  DW  current duty setpoint
//   direction  in  1   1 = step up by STEP, 0 = step down by STEP
//   next_duty  out DW  stepped duty, clamped to [DUTY_MIN, DUTY_MAX]
//   clamped    out 1   the step landed on or went past a limit
module duty_stepper
  import mppt_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int STEP     = DEF_STEP,
  parameter int DUTY_MIN = DEF_DUTY_MIN,
  parameter int DUTY_MAX = DEF_DUTY_MAX
) (
  input  logic [DW-1:0] duty,
  input  logic          direction,
  output logic [DW-1:0] next_duty,
  output logic          clamped
);

  // One extra bit so that duty + STEP cannot wrap past 2**DW.
  localparam logic [DW:0] STEP_X = (DW+1)'(STEP);
  localparam logic [DW:0] MIN_X  = (DW+1)'(DUTY_MIN);
  localparam logic [DW:0] MAX_X  = (DW+1)'(DUTY_MAX);

  // Returns {clamped, value}. Landing exactly on a limit counts as hitting
  // it, so the controller turns around as soon as it reaches the rail.
  // The down path compares before subtracting, so it never underflows.
  function automatic logic [DW:0] sat_step(input logic [DW-1:0] d,
                                           input logic          up);
    logic [DW:0] ext;
    logic [DW:0] raw;
    ext = {1'b0, d};
    raw = '0;
    if (up) begin
      raw = ext + STEP_X;
      if (raw >= MAX_X) sat_step = {1'b1, MAX_X[DW-1:0]};
      else              sat_step = {1'b0, raw[DW-1:0]};
    end else begin
      if (ext <= MIN_X + STEP_X) begin
        sat_step = {1'b1, MIN_X[DW-1:0]};
      end else begin
        raw      = ext - STEP_X;
        sat_step = {1'b0, raw[DW-1:0]};
      end
    end
  endfunction

  assign {clamped, next_duty} = sat_step(duty, direction);

endmodule

// File: rtl/mppt_po_controller.sv
// mppt_po_controller: perturb-and-observe MPPT sequencer.
// Each iteration: settle after a duty change, request one V/I sample, form
// power = v * i, compare with the previous power to pick the perturbation
// direction, then step the duty setpoint.
//   clk           in  1     system clock
//   reset         in  1     asynchronous, active-high reset
//   enable        in  1     level, high = tracking active
//   v_sample      in  DW    measured voltage, qualified by sample_valid
//   i_sample      in  DW    measured current, qualified by sample_valid
//   sample_valid  in  1     one-cycle strobe from the data collector
//   sample_req    out 1     one-cycle sample request pulse
//   duty          out DW    converter duty setpoint
//   direction     out 1     1 = increasing duty, 0 = decreasing duty
//   power         out 2*DW  last computed power
//   busy          out 1     high in every state except IDLE
//   fault         out 1     sticky sample-timeout flag
module mppt_po_controller
  import mppt_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int STEP        = DEF_STEP,
  parameter int DUTY_MIN    = DEF_DUTY_MIN,
  parameter int DUTY_MAX    = DEF_DUTY_MAX,
  parameter int DUTY_INIT   = DEF_DUTY_INIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [DW-1:0]   v_sample,
  input  logic [DW-1:0]   i_sample,
  input  logic            sample_valid,
  output logic            sample_req,
  output logic [DW-1:0]   duty,
  output logic            direction,
  output logic [2*DW-1:0] power,
  output logic            busy,
  output logic            fault
);

  localparam int PWL = 2 * DW;
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DW-1:0]  INIT_V      = DW'(DUTY_INIT);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC - 1);
  localparam logic [TCW-1:0] TOUT_LOAD   = TCW'(TIMEOUT_CYC - 1);

  state_t          state, state_nxt;
  logic [SCW-1:0]  cnt;
  logic [TCW-1:0]  tcnt;
  logic [PWL-1:0]  p_prev;
  logic            first_flag;
  logic [DW-1:0]   stepped_duty;
  logic            step_clamped;

  duty_stepper #(
    .DW       (DW),
    .STEP     (STEP),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX)
  ) u_stepper (
    .duty      (duty),
    .direction (direction),
    .next_duty (stepped_duty),
    .clamped   (step_clamped)
  );

  // Outputs decoded straight from the state register.
  assign sample_req = (state == S_REQ);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_SETTLE;
        S_SETTLE:  if (cnt == '0) state_nxt = S_REQ;
        S_REQ:     state_nxt = S_WAIT;
        S_WAIT: begin
          if (sample_valid)     state_nxt = S_COMPARE;
          else if (tcnt == '0)  state_nxt = S_REQ;
        end
        S_COMPARE: state_nxt = S_UPDATE;
        S_UPDATE:  state_nxt = S_SETTLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty       <= INIT_V;
      direction  <= 1'b1;
      power      <= '0;
      fault      <= 1'b0;
      p_prev     <= '0;
      first_flag <= 1'b1;
      cnt        <= '0;
      tcnt       <= '0;
    end else if (!enable) begin
      // Dropping enable reloads the idle setpoint; power and fault persist.
      duty       <= INIT_V;
      direction  <= 1'b1;
      first_flag <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          duty       <= INIT_V;
          direction  <= 1'b1;
          first_flag <= 1'b1;
          fault      <= 1'b0;
          cnt        <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_REQ: begin
          tcnt <= TOUT_LOAD;
        end
        S_WAIT: begin
          if (sample_valid)    power <= PWL'(v_sample) * PWL'(i_sample);
          else if (tcnt == '0) fault <= 1'b1;
          else                 tcnt  <= tcnt - 1'b1;
        end
        S_COMPARE: begin
          // The first sample after enabling has nothing to compare against.
          if (first_flag)          first_flag <= 1'b0;
          else if (power < p_prev) direction  <= ~direction;
          p_prev <= power;
        end
        S_UPDATE: begin
          duty <= stepped_duty;
          if (step_clamped) direction <= ~direction;
          cnt  <= SETTLE_LOAD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mppt_po_controller.sv
// Directed bench for mppt_po_controller with a cycle-stepped behavioural
// model: the driver walks each tracking iteration phase by phase, computes
// the expected outputs with plain integer arithmetic, and a negedge process
// compares every output against those expectations on every cycle.
module tb_mppt_po_controller;

  localparam int DW     = 8;
  localparam int SETTLE = 16;
  localparam int TOUT   = 64;
  localparam int STEP   = 4;
  localparam int DMIN   = 16;
  localparam int DMAX   = 240;
  localparam int DINIT  = 128;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [DW-1:0]   v_sample;
  logic [DW-1:0]   i_sample;
  logic            sample_valid;
  logic            sample_req;
  logic [DW-1:0]   duty;
  logic            direction;
  logic [2*DW-1:0] power;
  logic            busy;
  logic            fault;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int req_cyc     = 0;
  int start_cyc   = 0;
  bit chk_en      = 0;

  // expected outputs for the current cycle
  int exp_duty, exp_power;
  bit exp_dir, exp_req, exp_busy, exp_fault;
  // model state
  int m_duty, m_prev;
  bit m_dir, m_first;

  mppt_po_controller #(
    .DW          (DW),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TOUT),
    .STEP        (STEP),
    .DUTY_MIN    (DMIN),
    .DUTY_MAX    (DMAX),
    .DUTY_INIT   (DINIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .v_sample     (v_sample),
    .i_sample     (i_sample),
    .sample_valid (sample_valid),
    .sample_req   (sample_req),
    .duty         (duty),
    .direction    (direction),
    .power        (power),
    .busy         (busy),
    .fault        (fault)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("duty", duty, exp_duty);
      chk("direction", direction, exp_dir);
      chk("power", power, exp_power);
      chk("sample_req", sample_req, exp_req);
      chk("busy", busy, exp_busy);
      chk("fault", fault, exp_fault);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_duty = DINIT; m_dir = 1; m_first = 1; m_prev = 0;
    exp_duty = DINIT; exp_dir = 1; exp_power = 0;
    exp_req = 0; exp_busy = 0; exp_fault = 0;
  endtask

  task automatic model_idle();
    m_duty = DINIT; m_dir = 1; m_first = 1;
    exp_duty = DINIT; exp_dir = 1; exp_req = 0; exp_busy = 0;
  endtask

  // From the IDLE cycle in which enable is high, move into the first SETTLE cycle.
  task automatic start_tracking();
    enable = 1;
    step();
    exp_busy = 1; exp_fault = 0;
  endtask

  // Settle period then the request cycle; leaves the bench in the REQ cycle.
  task automatic settle_and_req(input bit spur);
    exp_busy = 1; exp_req = 0;
    for (int k = 0; k < SETTLE; k++) begin
      if (spur && k == 5) begin
        sample_valid = 1; v_sample = 255; i_sample = 255;
      end
      step();
      sample_valid = 0;
    end
    exp_req = 1;
    req_cyc = cyc;
  endtask

  // One full iteration. Entry: first SETTLE cycle. Exit: first SETTLE cycle
  // of the next iteration. touts request timeouts happen before the sample,
  // which then arrives in the w-th WAIT cycle.
  task automatic iterate(input int v, input int i, input int w,
                         input int touts, input bit spur);
    int p, nd;
    settle_and_req(spur);
    for (int t = 0; t < touts; t++) begin
      step();
      exp_req = 0;
      repeat (TOUT) step();
      exp_req = 1; exp_fault = 1;
    end
    step();
    exp_req = 0;
    for (int j = 1; j <= w; j++) begin
      if (j == w) begin
        sample_valid = 1; v_sample = DW'(v); i_sample = DW'(i);
      end
      step();
      sample_valid = 0;
    end
    // COMPARE cycle: new power visible
    p = v * i;
    exp_power = p;
    if (!m_first && p < m_prev) m_dir = !m_dir;
    m_first = 0;
    m_prev  = p;
    step();
    // UPDATE cycle: direction from the comparison visible
    exp_dir = m_dir;
    if (m_dir) begin
      nd = m_duty + STEP;
      if (nd >= DMAX) begin nd = DMAX; m_dir = 0; end
    end else begin
      nd = m_duty - STEP;
      if (nd <= DMIN) begin nd = DMIN; m_dir = 1; end
    end
    m_duty = nd;
    step();
    exp_duty = m_duty;
    exp_dir  = m_dir;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 0; enable = 0; sample_valid = 0; v_sample = 0; i_sample = 0;
    model_reset();
    #2 reset = 1;
    chk_en = 1;
    step();
    step();
    chk("reset_duty", duty, 128);
    chk("reset_busy", busy, 0);

    // Release reset with enable already high.
    enable = 1;
    step();
    reset = 0;
    start_cyc = cyc;
    start_tracking();

    // Rising power: 5000 then 5500 keeps climbing.
    iterate(100, 50, 3, 0, 0);
    chk("first_req_cycle", req_cyc - start_cyc, 17);
    chk("pwr_5000", power, 5000);
    chk("duty_132", duty, 132);
    iterate(110, 50, 5, 0, 1);
    chk("pwr_5500", power, 5500);
    chk("duty_136", duty, 136);
    chk("dir_up", direction, 1);

    // Power drops: reverse.
    iterate(100, 50, 1, 0, 0);
    chk("dir_down", direction, 0);
    chk("duty_132b", duty, 132);

    // Equal power, sample on the last legal WAIT cycle: keep direction, no fault.
    iterate(100, 50, TOUT, 0, 0);
    chk("equal_keep_dir", direction, 0);
    chk("duty_128", duty, 128);
    chk("no_fault_late_valid", fault, 0);

    // One timeout, then a lower power sample: reverse, fault sticks.
    iterate(90, 50, 2, 1, 0);
    chk("timeout_fault", fault, 1);
    chk("dir_up_again", direction, 1);
    chk("duty_132c", duty, 132);

    // Climb with rising power to the upper rail.
    k = 0;
    while (m_duty != DMAX && k < 40) begin
      iterate(100 + k, 50, 2, 0, 0);
      k++;
    end
    chk("clamp_max_duty", duty, 240);
    chk("clamp_max_dir", direction, 0);
    iterate(100 + k, 50, 2, 0, 0);
    k++;
    chk("after_max_duty", duty, 236);

    // Descend with rising power to the lower rail.
    while (m_duty != DMIN && k < 120) begin
      iterate(100 + k, 50, 2, 0, 0);
      k++;
    end
    chk("clamp_min_duty", duty, 16);
    chk("clamp_min_dir", direction, 1);

    // Full-width product.
    iterate(255, 255, 4, 0, 0);
    chk("pwr_full", power, 65025);
    chk("duty_20", duty, 20);

    // Drop enable during WAIT; late sample ignored.
    settle_and_req(0);
    step();
    exp_req = 0;
    repeat (2) step();
    enable = 0;
    step();
    model_idle();
    chk("drop_busy", busy, 0);
    chk("drop_duty", duty, 128);
    sample_valid = 1; v_sample = 200; i_sample = 200;
    step();
    sample_valid = 0;
    repeat (3) step();
    chk("late_valid_ignored", power, 65025);
    chk("fault_held_idle", fault, 1);

    // Re-enable: fault clears, first sample keeps direction despite low power.
    start_tracking();
    chk("fault_cleared", fault, 0);
    iterate(50, 40, 2, 1, 0);
    chk("first_keeps_dir", direction, 1);
    chk("duty_132d", duty, 132);

    // Asynchronous reset in SETTLE.
    repeat (3) step();
    #2 reset = 1;
    model_reset();
    #1;
    chk("async_duty", duty, 128);
    chk("async_power", power, 0);
    chk("async_fault", fault, 0);
    chk("async_busy", busy, 0);
    enable = 0;
    repeat (2) step();
    reset = 0;
    repeat (3) step();
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
